// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared requester IDs and default widths for the writeback arbiter
package regfile_wb_arbiter_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - requester handshakes and register-file write port bundle
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) ();

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, conflict_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// rtl/regfile_wb_arbiter_rr_arbiter_2.sv - two-way round-robin grant with last-grant pointer
module rr_arbiter_2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_MEM;
    end else if (en && (gnt != 2'b00)) begin
      last_grant <= gnt[REQ_MEM] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and load writeback
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        gnt;
  logic              accept_alu;
  logic              accept_mem;
  logic              accept;
  logic              both_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .req   ({bus.mem_valid, bus.alu_valid}),
    .gnt   (gnt)
  );

  assign bus.alu_ready = en & gnt[REQ_ALU] & ~reset;
  assign bus.mem_ready = en & gnt[REQ_MEM] & ~reset;

  assign accept_alu = bus.alu_valid & bus.alu_ready;
  assign accept_mem = bus.mem_valid & bus.mem_ready;
  assign accept     = accept_alu | accept_mem;
  assign both_valid = en & bus.alu_valid & bus.mem_valid;

  assign sel_addr = accept_mem ? bus.mem_addr : bus.alu_addr;
  assign sel_data = accept_mem ? bus.mem_data : bus.alu_data;

  // r0 writes are still consumed so the requester and pointer move on; only the strobe is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      rf_we_q <= accept && (sel_addr != '0);
      if (accept) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
      if (both_valid && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_pass   = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) bus ();
  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(2))  bus2 ();

  assign bus.alu_valid  = alu_valid;
  assign bus.alu_addr   = alu_addr;
  assign bus.alu_data   = alu_data;
  assign bus.mem_valid  = mem_valid;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_data   = mem_data;
  assign bus2.alu_valid = alu_valid;
  assign bus2.alu_addr  = alu_addr;
  assign bus2.alu_data  = alu_data;
  assign bus2.mem_valid = mem_valid;
  assign bus2.mem_addr  = mem_addr;
  assign bus2.mem_data  = mem_data;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(2)) u_dut_small (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic readies(input string name, input logic a, input logic m);
    #1;
    check({name, "_alu_ready"}, 32'(bus.alu_ready), 32'(a));
    check({name, "_mem_ready"}, 32'(bus.mem_ready), 32'(m));
  endtask

  task automatic reset_pulse();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Monitor: every write strobe must match the next expected write, in order.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected_we", 32'(bus.rf_we), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("wb_addr", 32'(bus.rf_waddr), 32'(w.addr));
          check("wb_data", bus.rf_wdata, w.data);
        end
      end
    end
  end

  // A requester that was not granted must hold valid and payload.
  logic        alu_pend = 1'b0, mem_pend = 1'b0;
  logic [4:0]  alu_addr_p, mem_addr_p;
  logic [31:0] alu_data_p, mem_data_p;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (alu_pend)
        assert (alu_valid && alu_addr == alu_addr_p && alu_data == alu_data_p)
          else $error("alu requester dropped or changed a pending request");
      if (mem_pend)
        assert (mem_valid && mem_addr == mem_addr_p && mem_data == mem_data_p)
          else $error("mem requester dropped or changed a pending request");
      alu_pend   = alu_valid & ~bus.alu_ready & ~reset;
      mem_pend   = mem_valid & ~bus.mem_ready & ~reset;
      alu_addr_p = alu_addr;
      alu_data_p = alu_data;
      mem_addr_p = mem_addr;
      mem_data_p = mem_data;
    end
  end

  initial begin
    reset     = 1'b1;
    en        = 1'b1;
    alu_valid = 1'b1;
    alu_addr  = 5'd1;
    alu_data  = 32'h1;
    mem_valid = 1'b1;
    mem_addr  = 5'd2;
    mem_data  = 32'h2;

    // Reset held three cycles with both requesters valid
    for (int i = 0; i < 3; i++) begin
      cyc();
      readies("reset", 1'b0, 1'b0);
    end
    check("reset_rf_we", 32'(bus.rf_we), 32'd0);
    check("reset_waddr", 32'(bus.rf_waddr), 32'd0);
    check("reset_wdata", bus.rf_wdata, 32'd0);
    check("reset_cnt", 32'(bus.conflict_cnt), 32'd0);
    check("reset_cnt_small", 32'(bus2.conflict_cnt), 32'd0);
    reset     = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;

    // Single ALU write, visible the following cycle
    cyc();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    push(5'd5, 32'h1234);
    readies("single", 1'b1, 1'b0);
    cyc();
    alu_valid = 1'b0;
    #1;
    check("single_rf_we", 32'(bus.rf_we), 32'd1);
    check("single_waddr", 32'(bus.rf_waddr), 32'd5);
    check("single_wdata", bus.rf_wdata, 32'h1234);

    // First tie after reset goes to ALU
    reset_pulse();
    cyc();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hB;
    push(5'd3, 32'hA);
    push(5'd4, 32'hB);
    readies("tie0", 1'b1, 1'b0);
    cyc();
    alu_valid = 1'b0;
    readies("tie1", 1'b0, 1'b1);
    cyc();
    mem_valid = 1'b0;
    #1;
    check("tie_cnt", 32'(bus.conflict_cnt), 32'd1);
    check("tie_cnt_small", 32'(bus2.conflict_cnt), 32'd1);

    // Six cycles of contention: ALU, MEM, ALU, MEM, ALU, MEM, then trailing ALU
    reset_pulse();
    for (int k = 0; k < 3; k++) begin
      push(5'(10 + k), 32'hA0 + 32'(k));
      push(5'(20 + k), 32'hB0 + 32'(k));
    end
    push(5'd13, 32'hA3);
    for (int i = 0; i < 6; i++) begin
      cyc();
      alu_valid = 1'b1; alu_addr = 5'(10 + (i + 1) / 2); alu_data = 32'hA0 + 32'((i + 1) / 2);
      mem_valid = 1'b1; mem_addr = 5'(20 + i / 2);       mem_data = 32'hB0 + 32'(i / 2);
      readies($sformatf("contend%0d", i), (i % 2) == 0, (i % 2) == 1);
    end
    cyc();
    mem_valid = 1'b0;
    readies("contend_tail", 1'b1, 1'b0);
    cyc();
    alu_valid = 1'b0;
    #1;
    check("contend_cnt", 32'(bus.conflict_cnt), 32'd6);
    check("contend_cnt_sat", 32'(bus2.conflict_cnt), 32'd3);

    // r0 write: accepted, no strobe, pointer moves to MEM
    cyc();
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFF;
    readies("r0", 1'b0, 1'b1);
    cyc();
    mem_valid = 1'b0;
    #1;
    check("r0_rf_we", 32'(bus.rf_we), 32'd0);
    check("r0_waddr", 32'(bus.rf_waddr), 32'd0);
    check("r0_wdata", bus.rf_wdata, 32'hFF);
    cyc();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'h88;
    push(5'd7, 32'h77);
    push(5'd8, 32'h88);
    readies("r0_tie0", 1'b1, 1'b0);
    cyc();
    alu_valid = 1'b0;
    readies("r0_tie1", 1'b0, 1'b1);
    cyc();
    mem_valid = 1'b0;

    // en=0 freezes grants and counter; order resumes from held pointer (MEM last)
    cyc();
    en = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h99;
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h1010;
    readies("frz0", 1'b0, 1'b0);
    cyc();
    readies("frz1", 1'b0, 1'b0);
    check("frz_cnt", 32'(bus.conflict_cnt), 32'd7);
    check("frz_rf_we", 32'(bus.rf_we), 32'd0);
    cyc();
    en = 1'b1;
    push(5'd9, 32'h99);
    push(5'd10, 32'h1010);
    readies("thaw0", 1'b1, 1'b0);
    cyc();
    alu_valid = 1'b0;
    readies("thaw1", 1'b0, 1'b1);
    cyc();
    mem_valid = 1'b0;
    #1;
    check("thaw_cnt", 32'(bus.conflict_cnt), 32'd8);
    check("thaw_cnt_small", 32'(bus2.conflict_cnt), 32'd3);

    repeat (3) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
